ifu: RTL

- Instruction fetch unit: the stage directly upstream of the decode/execute core.
- Owns the PC and issues 32-bit fetch requests on a valid/ready memory request channel, then accepts the response.
- Presents each fetched instruction to the decoder with a valid/ready handshake.
- Advances to the next PC only when the downstream stage commits the instruction and returns its dnpc.

---
 rtl/npc_pkg.sv | 21 ++
 rtl/ifu_timeout_cnt.sv | 38 +++
 rtl/ifu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared types for the fetch front end.
// Fault codes, IFU states and the default boot PC.
package npc_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    BUSERR   = 2'd2,
    TIMEOUT  = 2'd3
  } fetch_fault_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_NPC  = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Saturating response-wait counter.
// expire is high once the count reaches TIMEOUT_CYCLES-1.
module ifu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] MAX = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == MAX);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time
// and hands it to decode; the next PC comes back from commit.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_fault,
  input  logic        commit_valid,
  input  logic [31:0] commit_dnpc,
  output logic        busy
);

  ifu_state_t   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  fetch_fault_t fault_q, fault_d;
  logic         tmr_clr;
  logic         tmr_en;
  logic         tmr_exp;
  logic         misaligned;

  ifu_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_exp)
  );

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        tmr_clr = 1'b1;
        if (misaligned) begin
          inst_d    = '0;
          inst_pc_d = pc_q;
          fault_d   = MISALIGN;
          state_d   = S_HOLD;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response arriving on the expiry cycle still wins
        if (mem_resp_valid) begin
          inst_d    = mem_resp_err ? 32'h0 : mem_resp_data;
          inst_pc_d = pc_q;
          fault_d   = mem_resp_err ? BUSERR : NONE;
          state_d   = S_HOLD;
        end else if (tmr_exp) begin
          inst_d    = '0;
          inst_pc_d = pc_q;
          fault_d   = TIMEOUT;
          state_d   = S_HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          if (commit_valid) begin
            pc_d    = commit_dnpc;
            state_d = S_REQ;
          end else begin
            state_d = S_NPC;
          end
        end
      end
      S_NPC: begin
        if (commit_valid) begin
          pc_d    = commit_dnpc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ) && !misaligned;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == S_HOLD);
  assign busy          = (state_q == S_REQ) || (state_q == S_WAIT);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = fault_q;

endmodule
